// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/CALL/RET next-PC selection with a
// vectored interrupt and a DEPTH-entry return stack shared by CALL and interrupts.
module pc_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  localparam int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] k,
  input  logic               c,
  input  logic               z,
  input  logic               n,
  input  logic               int_req,
  input  logic [PC_W-1:0]    int_v,
  output logic [PC_W-1:0]    q_pc,
  output logic               branch,
  output logic               int_ack,
  output logic               ie,
  output logic [SP_W-1:0]    sp,
  output logic               stk_ovf,
  output logic               stk_unf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 1'b1;
  endfunction

  logic [PC_W-1:0]  stack [DEPTH];
  logic [3:0]       opcode;
  logic [3:0]       cond;
  logic             is_f;
  logic             full;
  logic             empty;
  logic             is_call;
  logic             is_ret;
  logic             is_reti;
  logic             cond_ok;
  logic             jump_taken;
  logic             push_call;
  logic             do_pop;
  logic             int_accept;
  logic [PC_W-1:0]  seq;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;

  assign opcode   = k[INSTR_W-1 -: 4];
  assign cond     = k[INSTR_W-5 -: 4];
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - 1'b1);

  generate
    if (INSTR_W > PC_W + 8) begin : g_unused_k
      logic unused_k;
      assign unused_k = ^k[INSTR_W-9:PC_W];
    end
  endgenerate

  // Decode and next-PC select
  always_comb begin
    is_f    = (opcode == 4'hF);
    full    = (sp == SP_FULL);
    empty   = (sp == '0);
    is_call = is_f && (cond == 4'h7);
    is_ret  = is_f && ((cond == 4'h8) || (cond == 4'h9));
    is_reti = is_f && (cond == 4'h9);
    case (cond)
      4'h0:    cond_ok = 1'b1;
      4'h1:    cond_ok = z;
      4'h2:    cond_ok = ~z;
      4'h3:    cond_ok = c;
      4'h4:    cond_ok = ~c;
      4'h5:    cond_ok = n;
      4'h6:    cond_ok = ~n;
      default: cond_ok = 1'b0;
    endcase
    jump_taken = is_f && cond_ok;
    // Full/empty stack suppresses the CALL/RET so it degrades to pc+1
    push_call  = is_call && !full;
    do_pop     = is_ret && !empty;
    branch     = jump_taken || push_call || do_pop;
    seq        = pc_inc(q_pc);
    if (jump_taken || push_call) begin
      seq = k[PC_W-1:0];
    end else if (do_pop) begin
      seq = stack[pop_idx];
    end
    // Never interrupt a stack-touching instruction, so only one push/pop per edge
    int_accept = int_req && ie && !full && !(is_call || is_ret);
  end

  // Registered control state
  always_ff @(posedge clk) begin
    if (rst) begin
      q_pc    <= '0;
      sp      <= '0;
      ie      <= 1'b1;
      int_ack <= 1'b0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      int_ack <= int_accept;
      if (int_accept) begin
        q_pc <= int_v;
        sp   <= sp + 1'b1;
        ie   <= 1'b0;
      end else begin
        q_pc <= seq;
        if (push_call) begin
          sp <= sp + 1'b1;
        end else if (do_pop) begin
          sp <= sp - 1'b1;
        end
        if (is_reti) ie <= 1'b1;
        if (is_call && full) stk_ovf <= 1'b1;
        if (is_ret && empty) stk_unf <= 1'b1;
      end
    end
  end

  // Return-stack storage
  always_ff @(posedge clk) begin
    if (int_accept) begin
      stack[push_idx] <= seq;
    end else if (push_call) begin
      stack[push_idx] <= pc_inc(q_pc);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push hand-computed
// expectations; a monitor pops and compares once per clock.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] k;
  logic        c, z, n;
  logic        int_req;
  logic [7:0]  int_v;
  logic [7:0]  q_pc;
  logic        branch;
  logic        int_ack;
  logic        ie;
  logic [2:0]  sp;
  logic        stk_ovf;
  logic        stk_unf;

  pc_sequencer #(.PC_W(8), .INSTR_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .k(k), .c(c), .z(z), .n(n),
    .int_req(int_req), .int_v(int_v), .q_pc(q_pc), .branch(branch),
    .int_ack(int_ack), .ie(ie), .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       br;
    logic [7:0] pc;
    logic [2:0] sp;
    logic       ie;
    logic       ack;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;
  bit   stim_done = 1'b0;
  bit   mon_done  = 1'b0;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
  endtask

  task automatic step(input logic r, input logic [15:0] kk, input logic cc, input logic zz,
                      input logic nn, input logic ir, input logic [7:0] iv,
                      input logic ebr, input logic [7:0] epc, input logic [2:0] esp,
                      input logic eie, input logic eack, input logic eovf, input logic eunf);
    exp_t e;
    rst = r; k = kk; c = cc; z = zz; n = nn; int_req = ir; int_v = iv;
    step_id++;
    e.id = step_id; e.br = ebr; e.pc = epc; e.sp = esp;
    e.ie = eie; e.ack = eack; e.ovf = eovf; e.unf = eunf;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: branch sampled mid-cycle, registered outputs just after the edge
  initial begin
    exp_t e;
    logic br_s;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        br_s = branch;
        @(posedge clk);
        #1;
        chk("branch",  e.id, {7'd0, br_s},    {7'd0, e.br});
        chk("q_pc",    e.id, q_pc,            e.pc);
        chk("sp",      e.id, {5'd0, sp},      {5'd0, e.sp});
        chk("ie",      e.id, {7'd0, ie},      {7'd0, e.ie});
        chk("int_ack", e.id, {7'd0, int_ack}, {7'd0, e.ack});
        chk("stk_ovf", e.id, {7'd0, stk_ovf}, {7'd0, e.ovf});
        chk("stk_unf", e.id, {7'd0, stk_unf}, {7'd0, e.unf});
      end else if (stim_done) begin
        mon_done = 1'b1;
        break;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; k = 16'h0000; c = 0; z = 0; n = 0; int_req = 0; int_v = 8'h00;
    @(posedge clk);
    #2;
    // reset and sequential count
    step(1, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h00, 3'd0, 1,0,0,0);
    step(1, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h00, 3'd0, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h01, 3'd0, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h02, 3'd0, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h03, 3'd0, 1,0,0,0);
    // conditional branches and wrap
    step(0, 16'hF00A, 0,0,0, 0,8'h00, 1, 8'h0A, 3'd0, 1,0,0,0);
    step(0, 16'hF140, 0,1,0, 0,8'h00, 1, 8'h40, 3'd0, 1,0,0,0);
    step(0, 16'hF150, 0,0,0, 0,8'h00, 0, 8'h41, 3'd0, 1,0,0,0);
    step(0, 16'hF260, 0,1,0, 0,8'h00, 0, 8'h42, 3'd0, 1,0,0,0);
    step(0, 16'hF370, 1,0,0, 0,8'h00, 1, 8'h70, 3'd0, 1,0,0,0);
    step(0, 16'hF480, 1,0,0, 0,8'h00, 0, 8'h71, 3'd0, 1,0,0,0);
    step(0, 16'hF590, 0,0,1, 0,8'h00, 1, 8'h90, 3'd0, 1,0,0,0);
    step(0, 16'hF6A0, 0,0,0, 0,8'h00, 1, 8'hA0, 3'd0, 1,0,0,0);
    step(0, 16'hFA55, 0,0,0, 0,8'h00, 0, 8'hA1, 3'd0, 1,0,0,0);
    step(0, 16'hF0FF, 0,0,0, 0,8'h00, 1, 8'hFF, 3'd0, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h00, 3'd0, 1,0,0,0);
    // nested CALL/RET
    step(0, 16'hF005, 0,0,0, 0,8'h00, 1, 8'h05, 3'd0, 1,0,0,0);
    step(0, 16'hF720, 0,0,0, 0,8'h00, 1, 8'h20, 3'd1, 1,0,0,0);
    step(0, 16'hF730, 0,0,0, 0,8'h00, 1, 8'h30, 3'd2, 1,0,0,0);
    step(0, 16'hF800, 0,0,0, 0,8'h00, 1, 8'h21, 3'd1, 1,0,0,0);
    step(0, 16'hF800, 0,0,0, 0,8'h00, 1, 8'h06, 3'd0, 1,0,0,0);
    // interrupt on NOP, held request, RETI, retaken
    step(0, 16'hF008, 0,0,0, 0,8'h00, 1, 8'h08, 3'd0, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 1,8'h80, 0, 8'h80, 3'd1, 0,1,0,0);
    step(0, 16'h0000, 0,0,0, 1,8'h80, 0, 8'h81, 3'd1, 0,0,0,0);
    step(0, 16'hF900, 0,0,0, 1,8'h80, 1, 8'h09, 3'd0, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 1,8'h80, 0, 8'h80, 3'd1, 0,1,0,0);
    step(0, 16'hF900, 0,0,0, 0,8'h80, 1, 8'h0A, 3'd0, 1,0,0,0);
    // interrupt folded into a taken JMP
    step(0, 16'hF012, 0,0,0, 0,8'h00, 1, 8'h12, 3'd0, 1,0,0,0);
    step(0, 16'hF044, 0,0,0, 1,8'h90, 1, 8'h90, 3'd1, 0,1,0,0);
    step(0, 16'hF900, 0,0,0, 0,8'h90, 1, 8'h44, 3'd0, 1,0,0,0);
    // interrupt deferred across a CALL
    step(0, 16'hF760, 0,0,0, 1,8'h90, 1, 8'h60, 3'd1, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 1,8'h90, 0, 8'h90, 3'd2, 0,1,0,0);
    step(0, 16'hF900, 0,0,0, 0,8'h90, 1, 8'h61, 3'd1, 1,0,0,0);
    step(0, 16'hF800, 0,0,0, 0,8'h90, 1, 8'h45, 3'd0, 1,0,0,0);
    // overflow, deferred interrupt when full, underflow, sticky flags
    step(0, 16'hF710, 0,0,0, 0,8'h00, 1, 8'h10, 3'd1, 1,0,0,0);
    step(0, 16'hF711, 0,0,0, 0,8'h00, 1, 8'h11, 3'd2, 1,0,0,0);
    step(0, 16'hF712, 0,0,0, 0,8'h00, 1, 8'h12, 3'd3, 1,0,0,0);
    step(0, 16'hF713, 0,0,0, 0,8'h00, 1, 8'h13, 3'd4, 1,0,0,0);
    step(0, 16'hF714, 0,0,0, 0,8'h00, 0, 8'h14, 3'd4, 1,0,1,0);
    step(0, 16'h0000, 0,0,0, 1,8'h90, 0, 8'h15, 3'd4, 1,0,1,0);
    step(0, 16'h0000, 0,0,0, 1,8'h90, 0, 8'h16, 3'd4, 1,0,1,0);
    step(0, 16'hF800, 0,0,0, 0,8'h00, 1, 8'h13, 3'd3, 1,0,1,0);
    step(0, 16'hF800, 0,0,0, 0,8'h00, 1, 8'h12, 3'd2, 1,0,1,0);
    step(0, 16'hF800, 0,0,0, 0,8'h00, 1, 8'h11, 3'd1, 1,0,1,0);
    step(0, 16'hF800, 0,0,0, 0,8'h00, 1, 8'h46, 3'd0, 1,0,1,0);
    step(0, 16'hF800, 0,0,0, 0,8'h00, 0, 8'h47, 3'd0, 1,0,1,1);
    step(0, 16'hF900, 0,0,0, 0,8'h00, 0, 8'h48, 3'd0, 1,0,1,1);
    step(0, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h49, 3'd0, 1,0,1,1);
    step(1, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h00, 3'd0, 1,0,0,0);
    step(0, 16'h0000, 0,0,0, 0,8'h00, 0, 8'h01, 3'd0, 1,0,0,0);
    stim_done = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
    if (!mon_done) begin
      n_checks++;
      $display("FAIL monitor_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
